// File: rtl/counter_pkg.sv
// Shared constants for the nested clause / LA-chunk counter.
//   CNT_W             : width of every count output
//   CLAUSES_DEFAULT   : default number of clauses (outer digit modulus)
//   LA_CHUNKS_DEFAULT : default LA chunks per clause (inner digit modulus)
package counter_pkg;

  localparam int unsigned CNT_W             = 17;
  localparam int unsigned CLAUSES_DEFAULT   = 2000;
  localparam int unsigned LA_CHUNKS_DEFAULT = 49;

endpackage

// File: rtl/counter_stage.sv
// Modulo-N counter digit with enable and wrap-carry.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   en    : advance the count on this edge
//   count : current value, always in 0..N-1
//   carry : high while count sits at N-1 (the next enabled edge wraps);
//           ungated so a chain of stages can AND the carries together
module counter_stage
  import counter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             carry
);

  assign carry = (count == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= carry ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/counter.sv
// Nested two-digit counter producing a ROM address (clause) and offset
// (LA chunk). The inner digit counts LA chunks; the outer digit advances
// when the inner digit wraps. Both wrap together at the final position.
//   clk            : rising-edge clock
//   rst_flag       : asynchronous active-low reset
//   stop_flag      : active-high hold, overrides counting
//   clause_count   : outer digit, 0..CLAUSES-1
//   la_chunk_count : inner digit, 0..LA_CHUNKS-1
//   last           : combinational, high at the final position
//   flat_addr      : linear index clause*LA_CHUNKS + chunk, only when
//                    COUNTER_FLAT_ADDR_EN is defined
module counter
  import counter_pkg::*;
#(
  parameter int unsigned CLAUSES   = CLAUSES_DEFAULT,
  parameter int unsigned LA_CHUNKS = LA_CHUNKS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_flag,
  input  logic             stop_flag,
  output logic [CNT_W-1:0] clause_count,
  output logic [CNT_W-1:0] la_chunk_count,
  output logic             last
`ifdef COUNTER_FLAT_ADDR_EN
  ,
  output logic [CNT_W-1:0] flat_addr
`endif
);

  logic en;
  logic inner_carry;
  logic outer_carry;

  assign en = !stop_flag;

  counter_stage #(
    .N (LA_CHUNKS)
  ) u_inner (
    .clk   (clk),
    .rst_n (rst_flag),
    .en    (en),
    .count (la_chunk_count),
    .carry (inner_carry)
  );

  // Outer digit only moves on the edge where the inner digit wraps.
  counter_stage #(
    .N (CLAUSES)
  ) u_outer (
    .clk   (clk),
    .rst_n (rst_flag),
    .en    (en && inner_carry),
    .count (clause_count),
    .carry (outer_carry)
  );

  assign last = inner_carry && outer_carry;

`ifdef COUNTER_FLAT_ADDR_EN
  // Running linear index kept in step with the digits; avoids a multiplier.
  always_ff @(posedge clk or negedge rst_flag) begin
    if (!rst_flag) begin
      flat_addr <= '0;
    end else if (en) begin
      flat_addr <= last ? '0 : flat_addr + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_counter.sv
module tb_counter;

  logic        clk = 1'b0;
  logic        rst_flag;
  logic        stop_flag;
  logic [16:0] clause_count;
  logic [16:0] la_chunk_count;
  logic        last;
`ifdef COUNTER_FLAT_ADDR_EN
  logic [16:0] flat_addr;
`endif

  // Small side instances for the single-digit boundary cases.
  logic [16:0] n1_clause, n1_chunk, c1_clause, c1_chunk;
  logic        n1_last, c1_last;
`ifdef COUNTER_FLAT_ADDR_EN
  logic [16:0] n1_flat, c1_flat;
`endif

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  counter dut (
    .clk            (clk),
    .rst_flag       (rst_flag),
    .stop_flag      (stop_flag),
    .clause_count   (clause_count),
    .la_chunk_count (la_chunk_count),
    .last           (last)
`ifdef COUNTER_FLAT_ADDR_EN
    ,
    .flat_addr      (flat_addr)
`endif
  );

  counter #(.CLAUSES(3), .LA_CHUNKS(1)) u_n1 (
    .clk            (clk),
    .rst_flag       (rst_flag),
    .stop_flag      (stop_flag),
    .clause_count   (n1_clause),
    .la_chunk_count (n1_chunk),
    .last           (n1_last)
`ifdef COUNTER_FLAT_ADDR_EN
    ,
    .flat_addr      (n1_flat)
`endif
  );

  counter #(.CLAUSES(1), .LA_CHUNKS(4)) u_c1 (
    .clk            (clk),
    .rst_flag       (rst_flag),
    .stop_flag      (stop_flag),
    .clause_count   (c1_clause),
    .la_chunk_count (c1_chunk),
    .last           (c1_last)
`ifdef COUNTER_FLAT_ADDR_EN
    ,
    .flat_addr      (c1_flat)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Wait n rising edges, then settle to the following falling edge.
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_main(input string tag, input int unsigned cl, input int unsigned ch,
                          input logic lst, input int unsigned flat);
    chk({tag, ".clause"}, 32'(clause_count), 32'(cl));
    chk({tag, ".chunk"}, 32'(la_chunk_count), 32'(ch));
    chk({tag, ".last"}, 32'(last), 32'(lst));
`ifdef COUNTER_FLAT_ADDR_EN
    chk({tag, ".flat"}, 32'(flat_addr), 32'(flat));
`else
    if (flat > 32'd200000) $error("FAIL %s.flatarg: got %0d expected below 200000", tag, flat);
`endif
  endtask

  initial begin
    rst_flag  = 1'b0;
    stop_flag = 1'b1;
    #1;
    chk_main("reset_async", 0, 0, 1'b0, 0);
    tick(3);
    chk_main("reset_hold", 0, 0, 1'b0, 0);
    chk("n1_reset_clause", 32'(n1_clause), 32'd0);
    chk("c1_reset_last", 32'(c1_last), 32'd0);

    // Release reset; count 5 edges.
    stop_flag = 1'b0;
    rst_flag  = 1'b1;
    tick(5);
    chk_main("after5", 0, 5, 1'b0, 5);
    chk("n1_after5_clause", 32'(n1_clause), 32'd2);
    chk("n1_after5_chunk", 32'(n1_chunk), 32'd0);
    chk("c1_after5_chunk", 32'(c1_chunk), 32'd1);
    chk("c1_after5_clause", 32'(c1_clause), 32'd0);

    // Pause at chunk 7.
    tick(2);
    chk_main("at7", 0, 7, 1'b0, 7);
    stop_flag = 1'b1;
    tick(2);
    chk_main("stop_hold", 0, 7, 1'b0, 7);
    chk("c1_stop_last", 32'(c1_last), 32'd1);
    stop_flag = 1'b0;
    tick(1);
    chk_main("resume", 0, 8, 1'b0, 8);
    chk("n1_resume_clause", 32'(n1_clause), 32'd2);
    chk("c1_wrap_chunk", 32'(c1_chunk), 32'd0);

    // Inner wrap into clause 1.
    tick(41);
    chk_main("inner_wrap", 1, 0, 1'b0, 49);
    tick(3);
    chk_main("post_wrap3", 1, 3, 1'b0, 52);

    // Advance to clause 3, chunk 10, then reset between edges.
    tick(105);
    chk_main("clause3", 3, 10, 1'b0, 157);
    #2 rst_flag = 1'b0;
    #1;
    chk_main("midreset_async", 0, 0, 1'b0, 0);
    @(negedge clk);
    rst_flag = 1'b1;
    tick(1);
    chk_main("post_reset1", 0, 1, 1'b0, 1);

    // Run to the final position.
    tick(97998);
    chk_main("final", 1999, 48, 1'b1, 97999);
    stop_flag = 1'b1;
    tick(3);
    chk_main("final_stop", 1999, 48, 1'b1, 97999);
    stop_flag = 1'b0;
    tick(1);
    chk_main("full_wrap", 0, 0, 1'b0, 0);
    tick(1);
    chk_main("after_wrap", 0, 1, 1'b0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
